// File: rtl/demux1to16_tdm.sv
// demux1to16_tdm: TDM 1:16 lane demux; ports clk, rst_n (async low), in/in_valid/sync serial side, out/out_valid/sel/locked/frame_err parallel side, err_cnt when DEMUX_ERRCNT_EN
module demux1to16_tdm #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  input  logic                  sync,
  output logic [16*WIDTH-1:0]   out,
  output logic                  out_valid,
  output logic [3:0]            sel,
  output logic                  locked,
`ifdef DEMUX_ERRCNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  frame_err
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state, state_n;
  logic [3:0] sel_n, wsel;
  logic take, pub, restart;
  logic [15*WIDTH-1:0] shadow;
  always_comb begin
    wsel    = sync ? 4'd0 : sel;
    take    = in_valid && (state == RUN || sync);
    pub     = take && wsel == 4'd15;
    restart = in_valid && sync && state == RUN && sel != 4'd0;
    sel_n   = take ? wsel + 4'd1 : sel;
    state_n = (in_valid && sync) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sel       <= 4'd0;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      out_valid <= pub;
      frame_err <= restart;
      if (pub) out <= {in, shadow};
      for (int k = 0; k < 15; k++)
        if (take && wsel == 4'(k)) shadow[k*WIDTH +: WIDTH] <= in;
    end
  end
`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= 8'd0;
    else if (restart && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
  assign locked = state == RUN;
endmodule
